// File: rtl/i2c_seq_pkg.sv
// Shared types for the I2C init sequencer: FSM state codes,
// controller IDLE code, mode encodings and the table entry layout.
package i2c_seq_pkg;

  typedef logic [2:0] seq_state_t;

  localparam seq_state_t S_IDLE      = 3'd0;
  localparam seq_state_t S_LOAD      = 3'd1;
  localparam seq_state_t S_ISSUE     = 3'd2;
  localparam seq_state_t S_WAIT_DONE = 3'd3;
  localparam seq_state_t S_GAP       = 3'd4;
  localparam seq_state_t S_DONE      = 3'd5;
  localparam seq_state_t S_ERROR     = 3'd6;

  localparam logic [3:0] CTRL_IDLE = 4'd0;

  localparam logic SEQ_READ  = 1'b0;
  localparam logic SEQ_WRITE = 1'b1;

  typedef struct packed {
    logic [6:0] addr;
    logic [7:0] data;
    logic       mode;
  } seq_entry_t;

endpackage

// File: rtl/i2c_seq_rom.sv
// Constant init table: combinational index -> {addr, data, mode}.
// Ports: idx (entry index), entry (table record). Edit only this file to change the table.
module i2c_seq_rom
  import i2c_seq_pkg::*;
#(
  parameter int IW = 3
) (
  input  logic [IW-1:0] idx,
  output seq_entry_t    entry
);

  logic [31:0] sel;

  always_comb begin
    sel   = 32'(idx);
    entry = '{addr: 7'h00, data: 8'h00, mode: SEQ_WRITE};
    case (sel)
      32'd0:   entry = '{addr: 7'h1a, data: 8'h00, mode: SEQ_WRITE};
      32'd1:   entry = '{addr: 7'h1a, data: 8'h1f, mode: SEQ_WRITE};
      32'd2:   entry = '{addr: 7'h1a, data: 8'h23, mode: SEQ_WRITE};
      32'd3:   entry = '{addr: 7'h1a, data: 8'h45, mode: SEQ_WRITE};
      32'd4:   entry = '{addr: 7'h1a, data: 8'h67, mode: SEQ_WRITE};
      32'd5:   entry = '{addr: 7'h1a, data: 8'h89, mode: SEQ_WRITE};
      32'd6:   entry = '{addr: 7'h1a, data: 8'hab, mode: SEQ_WRITE};
      32'd7:   entry = '{addr: 7'h1b, data: 8'h00, mode: SEQ_READ};
      default: entry = '{addr: 7'h00, data: 8'h00, mode: SEQ_WRITE};
    endcase
  end

endmodule

// File: rtl/i2c_init_sequencer.sv
// Walks the ROM table, handing each entry to the I2C controller via enable.
// Ports: clk, reset (async active-low), start, ctrl_state in; enable,
// periph_addr, data_byte, mode, busy, done, error, index out.
// Optional watchdog: define I2C_SEQ_TIMEOUT_EN.
module i2c_init_sequencer
  import i2c_seq_pkg::*;
#(
  parameter  int NUM_ENTRIES    = 8,
  parameter  int GAP_CYCLES     = 64,
  parameter  int TIMEOUT_CYCLES = 4096,
  localparam int IW = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [3:0]    ctrl_state,
  output logic          enable,
  output logic [6:0]    periph_addr,
  output logic [7:0]    data_byte,
  output logic          mode,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [IW-1:0] index
);

  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  seq_state_t state;
  logic [GW-1:0] gap_cnt;
  seq_entry_t entry;
  logic ctrl_idle;
  logic last;
  logic timeout;

  i2c_seq_rom #(.IW(IW)) u_rom (
    .idx   (index),
    .entry (entry)
  );

  assign ctrl_idle = (ctrl_state == CTRL_IDLE);
  assign last      = (index == IW'(NUM_ENTRIES - 1));

`ifdef I2C_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] wd_cnt;

  // wd_cnt holds cycles already spent in ISSUE/WAIT_DONE.
  assign timeout = ((state == S_ISSUE) || (state == S_WAIT_DONE)) &&
                   (wd_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      wd_cnt <= '0;
    else if (state == S_LOAD)
      wd_cnt <= '0;
    else if ((state == S_ISSUE) || (state == S_WAIT_DONE))
      wd_cnt <= wd_cnt + 1'b1;
  end

  assign error = (state == S_ERROR);
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;

  assign timeout = 1'b0;
  assign error   = 1'b0;
`endif

  // Dropped in the very cycle the controller leaves IDLE so it
  // cannot retrigger when it returns to IDLE.
  assign enable = (state == S_ISSUE) && ctrl_idle && !timeout;

  assign busy = (state == S_LOAD) || (state == S_ISSUE) ||
                (state == S_WAIT_DONE) || (state == S_GAP);
  assign done = (state == S_DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      periph_addr <= '0;
      data_byte   <= '0;
      mode        <= SEQ_WRITE;
      index       <= '0;
      gap_cnt     <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            index <= '0;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          periph_addr <= entry.addr;
          data_byte   <= entry.data;
          mode        <= entry.mode;
          state       <= S_ISSUE;
        end
        S_ISSUE: begin
          if (timeout)
            state <= S_ERROR;
          else if (!ctrl_idle)
            state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (timeout) begin
            state <= S_ERROR;
          end else if (ctrl_idle) begin
            gap_cnt <= GW'(GAP_CYCLES);
            state   <= S_GAP;
          end
        end
        S_GAP: begin
          if (gap_cnt == '0) begin
            if (last) begin
              state <= S_DONE;
            end else begin
              index <= index + 1'b1;
              state <= S_LOAD;
            end
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        S_ERROR: state <= S_ERROR;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_init_sequencer.sv
// Self-checking bench: 8-entry/64-gap sequencer plus a 1-entry/0-gap
// sequencer, each driven by a behavioural I2C controller model.
module tb_i2c_init_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // DUT A: default parameters
  logic       start_a = 1'b0;
  logic [3:0] cs_a;
  logic       en_a, mode_a, busy_a, done_a, err_a;
  logic [6:0] addr_a;
  logic [7:0] byte_a;
  logic [2:0] index_a;

  // DUT B: one entry, no gap
  logic       start_b = 1'b0;
  logic [3:0] cs_b;
  logic       en_b, mode_b, busy_b, done_b, err_b;
  logic [6:0] addr_b;
  logic [7:0] byte_b;
  logic [0:0] index_b;

  i2c_init_sequencer u_dut_a (
    .clk (clk), .reset (rst_n), .start (start_a),
    .ctrl_state (cs_a), .enable (en_a),
    .periph_addr (addr_a), .data_byte (byte_a), .mode (mode_a),
    .busy (busy_a), .done (done_a), .error (err_a), .index (index_a)
  );

  i2c_init_sequencer #(.NUM_ENTRIES(1), .GAP_CYCLES(0)) u_dut_b (
    .clk (clk), .reset (rst_n), .start (start_b),
    .ctrl_state (cs_b), .enable (en_b),
    .periph_addr (addr_b), .data_byte (byte_b), .mode (mode_b),
    .busy (busy_b), .done (done_b), .error (err_b), .index (index_b)
  );

  typedef struct {
    logic [2:0] idx;
    logic [6:0] addr;
    logic [7:0] data;
    logic       mode;
  } rec_t;

  rec_t cap_q[$];
  int   en_cnt_a = 0;
  int   en_cnt_b = 0;
  int   busy_len_a = 40;
  int   ph_a, cnt_a, ph_b, cnt_b;

  // controller model A: leaves IDLE 4 cycles after enable, busy busy_len_a
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_a <= 0; cnt_a <= 0; cs_a <= 4'd0;
    end else begin
      case (ph_a)
        0: if (en_a) begin
          ph_a <= 1; cnt_a <= 3;
          en_cnt_a <= en_cnt_a + 1;
          cap_q.push_back('{index_a, addr_a, byte_a, mode_a});
        end
        1: if (cnt_a == 0) begin
          cs_a <= 4'd5; ph_a <= 2; cnt_a <= busy_len_a - 1;
        end else cnt_a <= cnt_a - 1;
        default: if (cnt_a == 0) begin
          cs_a <= 4'd0; ph_a <= 0;
        end else cnt_a <= cnt_a - 1;
      endcase
    end
  end

  // controller model B: same timing, fixed 40-cycle transaction
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_b <= 0; cnt_b <= 0; cs_b <= 4'd0;
    end else begin
      case (ph_b)
        0: if (en_b) begin
          ph_b <= 1; cnt_b <= 3; en_cnt_b <= en_cnt_b + 1;
        end
        1: if (cnt_b == 0) begin
          cs_b <= 4'd3; ph_b <= 2; cnt_b <= 39;
        end else cnt_b <= cnt_b - 1;
        default: if (cnt_b == 0) begin
          cs_b <= 4'd0; ph_b <= 0;
        end else cnt_b <= cnt_b - 1;
      endcase
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  rec_t vt[8];

  initial begin
    int base, k, snap;
    bit hit;

    vt[0] = '{3'd0, 7'h1a, 8'h00, 1'b1};
    vt[1] = '{3'd1, 7'h1a, 8'h1f, 1'b1};
    vt[2] = '{3'd2, 7'h1a, 8'h23, 1'b1};
    vt[3] = '{3'd3, 7'h1a, 8'h45, 1'b1};
    vt[4] = '{3'd4, 7'h1a, 8'h67, 1'b1};
    vt[5] = '{3'd5, 7'h1a, 8'h89, 1'b1};
    vt[6] = '{3'd6, 7'h1a, 8'hab, 1'b1};
    vt[7] = '{3'd7, 7'h1b, 8'h00, 1'b0};

    // reset values
    #13;
    chk("rst_enable", en_a, 0);
    chk("rst_addr", addr_a, 0);
    chk("rst_byte", byte_a, 0);
    chk("rst_mode", mode_a, 1);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_error", err_a, 0);
    chk("rst_index", index_a, 0);
    rst_n = 1'b1;
    tick();

    // single entry, zero gap
    start_b = 1'b1; tick(); start_b = 1'b0;
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      tick(); if (cs_b != 0) hit = 1;
    end
    chk("b_ctrl_busy_seen", hit, 1);
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      tick(); if (cs_b == 0) hit = 1;
    end
    chk("b_ctrl_idle_seen", hit, 1);
    chk("b_done_early", done_b, 0);
    tick(); tick();
    chk("b_done", done_b, 1);
    chk("b_busy", busy_b, 0);
    chk("b_enable_pulses", en_cnt_b, 1);
    chk("b_addr", addr_b, 7'h1a);
    chk("b_byte", byte_b, 8'h00);

    // full run on A
    base = cap_q.size();
    start_a = 1'b1; tick(); start_a = 1'b0;
    chk("a_en_in_load", en_a, 0);
    tick();
    chk("a_en_in_issue", en_a, 1);
    hit = 0;
    for (int i = 0; i < 5000 && !hit; i++) begin
      tick(); if (done_a) hit = 1;
    end
    chk("a_run1_done", hit, 1);
    chk("a_run1_busy", busy_a, 0);
    chk("a_run1_error", err_a, 0);
    chk("a_run1_count", cap_q.size() - base, 8);
    for (int i = 0; i < 8; i++) begin
      if (base + i < cap_q.size()) begin
        chk($sformatf("r1_idx%0d", i), cap_q[base+i].idx, vt[i].idx);
        chk($sformatf("r1_addr%0d", i), cap_q[base+i].addr, vt[i].addr);
        chk($sformatf("r1_data%0d", i), cap_q[base+i].data, vt[i].data);
        chk($sformatf("r1_mode%0d", i), cap_q[base+i].mode, vt[i].mode);
      end
    end

    // second run from DONE with start hammered during the run
    base = cap_q.size();
    start_a = 1'b1; tick(); start_a = 1'b0;
    chk("a_run2_index0", index_a, 0);
    chk("a_run2_done_clr", done_a, 0);
    hit = 0; k = 0;
    for (int i = 0; i < 5000 && !hit; i++) begin
      tick();
      if (done_a) hit = 1;
      else start_a = ((k++ % 5) == 0);
    end
    start_a = 1'b0;
    chk("a_run2_done", hit, 1);
    chk("a_run2_count", cap_q.size() - base, 8);
    for (int i = 0; i < 8; i++)
      if (base + i < cap_q.size())
        chk($sformatf("r2_idx%0d", i), cap_q[base+i].idx, vt[i].idx);

    // async reset while enable is high on entry 2
    start_a = 1'b1; tick(); start_a = 1'b0;
    hit = 0;
    for (int i = 0; i < 5000 && !hit; i++) begin
      tick(); if (index_a == 3'd2 && en_a) hit = 1;
    end
    chk("a_reach_entry2", hit, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("a_rst_enable", en_a, 0);
    chk("a_rst_busy", busy_a, 0);
    chk("a_rst_index", index_a, 0);
    #3 rst_n = 1'b1;
    snap = en_cnt_a;
    repeat (300) tick();
    chk("a_no_enable_after_rst", en_cnt_a, snap);
    chk("a_idle_after_rst", busy_a, 0);

    // stalled controller
    busy_len_a = 5000;
    start_a = 1'b1; tick(); start_a = 1'b0;
    tick();
    chk("a_stall_en", en_a, 1);
`ifdef I2C_SEQ_TIMEOUT_EN
    repeat (4095) tick();
    chk("a_stall_err_early", err_a, 0);
    tick();
    chk("a_stall_err", err_a, 1);
    chk("a_stall_en_off", en_a, 0);
    chk("a_stall_index", index_a, 0);
    chk("a_stall_busy", busy_a, 0);
`else
    repeat (4500) tick();
    chk("a_stall_err", err_a, 0);
    chk("a_stall_busy", busy_a, 1);
`endif
    rst_n = 1'b0;
    #4 rst_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
